// File: rtl/monitor_compuertas_if.sv
// Bus bundle between the gate stimulus side and the response checker.
// Carries the start/valid handshake, the applied stimulus pair, the gate
// responses, and the result outputs of the checker.
interface monitor_compuertas_if #(
   parameter int CNT_W = 8
);
   logic             start;
   logic             valid_in;
   logic             A;
   logic             B;
   logic             out_and;
   logic             out_or;
   logic             out_not;
   logic             busy;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] vec_count;
   logic [CNT_W-1:0] err_count;
   logic [2:0]       fail_flags;
   logic [CNT_W-1:0] first_fail_idx;
   logic [1:0]       first_fail_ab;

   // Stimulus side: drives the vectors and responses, reads back the results.
   modport master (
      output start, valid_in, A, B, out_and, out_or, out_not,
      input  busy, done, pass, vec_count, err_count, fail_flags,
             first_fail_idx, first_fail_ab
   );

   // Checker side.
   modport slave (
      input  start, valid_in, A, B, out_and, out_or, out_not,
      output busy, done, pass, vec_count, err_count, fail_flags,
             first_fail_idx, first_fail_ab
   );
endinterface

// File: rtl/monitor_compuertas.sv
// Response checker for the gate library.
// It compares the AND/OR/NOT responses against golden values derived from
// the applied A/B pair. Over a run of NUM_VECTORS valid samples it counts
// vectors and failing vectors, keeps sticky per-gate fail flags and records
// the first failing vector. It then reports done/pass.
module monitor_compuertas #(
   parameter int NUM_VECTORS = 4,
   parameter int CNT_W       = 8
) (
   input logic                  clk,
   input logic                  reset_L,
   monitor_compuertas_if.slave  bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_VECTORS);
   localparam logic [CNT_W-1:0] ERR_MAX  = {CNT_W{1'b1}};

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] vec_count_q, vec_count_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;
   logic [2:0]       fail_flags_q, fail_flags_d;
   logic [CNT_W-1:0] first_fail_idx_q, first_fail_idx_d;
   logic [1:0]       first_fail_ab_q, first_fail_ab_d;
   logic             pass_q, pass_d;

   logic [2:0]       mism;
   logic [CNT_W-1:0] vec_next;

   // Next-state logic. Golden comparison and run bookkeeping happen here.
   // A vector that mismatches on several gates still counts as one error.
   always_comb begin
      state_d          = state_q;
      vec_count_d      = vec_count_q;
      err_count_d      = err_count_q;
      fail_flags_d     = fail_flags_q;
      first_fail_idx_d = first_fail_idx_q;
      first_fail_ab_d  = first_fail_ab_q;
      pass_d           = pass_q;

      mism     = {bus.out_not ^ ~bus.A,
                  bus.out_or  ^ (bus.A | bus.B),
                  bus.out_and ^ (bus.A & bus.B)};
      vec_next = vec_count_q + CNT_ONE;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               state_d          = ST_RUN;
               vec_count_d      = '0;
               err_count_d      = '0;
               fail_flags_d     = '0;
               first_fail_idx_d = '0;
               first_fail_ab_d  = '0;
               pass_d           = 1'b0;
            end
         end
         ST_RUN: begin
            if (bus.valid_in) begin
               vec_count_d  = vec_next;
               fail_flags_d = fail_flags_q | mism;
               if (mism != 3'b000) begin
                  if (err_count_q != ERR_MAX) begin
                     err_count_d = err_count_q + CNT_ONE;
                  end
                  if (err_count_q == '0) begin
                     first_fail_idx_d = vec_count_q;
                     first_fail_ab_d  = {bus.A, bus.B};
                  end
               end
               if (vec_next == LAST_CNT) begin
                  state_d = ST_DONE;
                  pass_d  = (err_count_q == '0) && (mism == 3'b000);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and result registers. Reset aborts any run and clears every result.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q          <= ST_IDLE;
         vec_count_q      <= '0;
         err_count_q      <= '0;
         fail_flags_q     <= '0;
         first_fail_idx_q <= '0;
         first_fail_ab_q  <= '0;
         pass_q           <= 1'b0;
      end else begin
         state_q          <= state_d;
         vec_count_q      <= vec_count_d;
         err_count_q      <= err_count_d;
         fail_flags_q     <= fail_flags_d;
         first_fail_idx_q <= first_fail_idx_d;
         first_fail_ab_q  <= first_fail_ab_d;
         pass_q           <= pass_d;
      end
   end

   assign bus.busy           = (state_q == ST_RUN);
   assign bus.done           = (state_q == ST_DONE);
   assign bus.pass           = pass_q;
   assign bus.vec_count      = vec_count_q;
   assign bus.err_count      = err_count_q;
   assign bus.fail_flags     = fail_flags_q;
   assign bus.first_fail_idx = first_fail_idx_q;
   assign bus.first_fail_ab  = first_fail_ab_q;

endmodule

// File: doc/monitor_compuertas.md
Name: monitor_compuertas

Overview:
- Synthesizable response checker for the component library; it is the receiving end of the gate stimulus generator.
- It samples each applied stimulus pair (A, B) and the gate library responses (out_and, out_or, out_not), and compares the responses against golden values computed internally.
- It accumulates vector and error counts, per-gate sticky fail flags and a first-failure record, then reports pass/done after a programmed number of vectors.
- It sits beside the gate DUT in the library testbench so that checking no longer depends on reading $monitor text.

Parameters:
- NUM_VECTORS, 4, number of valid samples checked per run (1 to 2^CNT_W-1).
- CNT_W, 8, width of vec_count, err_count and first_fail_idx.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset_L  input  1  asynchronous, active-low reset.
- start  input  1  begins a run when sampled high in IDLE or DONE.
- valid_in  input  1  the current A/B/out_* values form one vector to check.
- A  input  1  stimulus bit A applied to the DUT.
- B  input  1  stimulus bit B applied to the DUT.
- out_and  input  1  DUT AND response.
- out_or  input  1  DUT OR response.
- out_not  input  1  DUT NOT response; the golden value is ~A.
- busy  output  1  high while in RUN.
- done  output  1  high while in DONE.
- pass  output  1  valid in DONE; 1 when err_count == 0.
- vec_count  output  CNT_W  vectors checked in the current run.
- err_count  output  CNT_W  failing vectors, saturating.
- fail_flags  output  3  sticky per-gate flags {not, or, and}; bit0 = AND.
- first_fail_idx  output  CNT_W  vec_count value of the first failing vector.
- first_fail_ab  output  2  {A, B} of the first failing vector.

Behaviour:
- Reset (reset_L low, asynchronous):
  - State is IDLE.
  - All outputs are 0 and all counters/flags are cleared.
  - Reset is released synchronously to clk by the bench.
- FSM states are IDLE, RUN and DONE. All outputs are registered.
- IDLE:
  - valid_in is ignored.
  - start=1 → RUN on the next edge; vec_count, err_count, fail_flags, first_fail_* and pass clear on that edge.
- RUN:
  - On each edge with valid_in=1, the block computes mism = {out_not^~A, out_or^(A|B), out_and^(A&B)}.
  - fail_flags |= mism.
  - vec_count increments.
  - If mism != 0: err_count increments, saturating at 2^CNT_W-1. A vector with several mismatching gates counts as one error.
  - First failing vector (err_count was 0): first_fail_idx = vec_count before the increment (0-based), and first_fail_ab = {A, B}.
  - When the accepted vector brings vec_count to NUM_VECTORS, the state moves to DONE on the same edge, and pass = (no error in the run, including this vector).
  - start is ignored in RUN.
  - valid_in=0 holds all state.
- Latency: outputs reflect a sampled vector one clk edge after the sample. done rises on the same edge that accepts the last vector.
- DONE:
  - All results hold and valid_in is ignored.
  - start=1 → RUN with results cleared, the same as from IDLE.
- Reset mid-run aborts immediately to IDLE with all outputs 0. No partial result is retained.
- Simultaneous start and valid_in in IDLE/DONE: start is taken, and the vector on that edge is not checked.
- X/Z on the inputs is not the block's concern. The bench drives only known values while valid_in=1.

Test Plan:
- Correct DUT, NUM_VECTORS=4, vectors AB=00,01,10,11 with valid_in each cycle after start → done high after the 4th edge, pass=1, vec_count=4, err_count=0, fail_flags=000.
- AND forced to 1 on vector index 2 (AB=10) → pass=0, err_count=1, fail_flags=001, first_fail_idx=2, first_fail_ab=10.
- Vector 1 (AB=01) with both out_or and out_not wrong, plus vector 3 (AB=11) with out_and wrong → err_count=2, fail_flags=111, first_fail_idx=1, first_fail_ab=01.
- CNT_W=2, NUM_VECTORS=3, every vector failing → err_count saturates at 3 without wrapping; done after 3 vectors.
- reset_L pulsed low after 2 vectors → all outputs 0 immediately (asynchronously), state IDLE. A later start plus 4 clean vectors → pass=1, vec_count=4.
- In DONE, valid_in toggling leaves the results unchanged. start → busy=1 with counters 0 on the next edge. A start pulse during RUN has no effect.
